ksa_rr_arbiter: RTL

KSA_RR_ARBITER -- requirements
Module: ksa_rr_arbiter

---
 rtl/ksa_pkg.sv | 13 +
 rtl/kogge_stone_adder.sv | 42 ++++
 rtl/ksa_rr_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/ksa_pkg.sv
// Shared definitions for the round-robin arbiter and its Kogge-Stone adder.
package ksa_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned DEFAULT_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/kogge_stone_adder.sv
// Parallel-prefix (Kogge-Stone) adder: {cout, sum} = a + b + cin.
module kogge_stone_adder
    import ksa_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    localparam int unsigned LVLS = $clog2(DATA_W);

    logic [DATA_W-1:0] g [LVLS+1];
    logic [DATA_W-1:0] p [LVLS+1];
    logic [DATA_W:0]   c;

    always_comb begin
        g[0] = a & b;
        p[0] = a ^ b;
        for (int unsigned l = 0; l < LVLS; l++) begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
                if (i >= (32'd1 << l)) begin
                    g[l+1][i] = g[l][i] | (p[l][i] & g[l][i - (32'd1 << l)]);
                    p[l+1][i] = p[l][i] & p[l][i - (32'd1 << l)];
                end else begin
                    g[l+1][i] = g[l][i];
                    p[l+1][i] = p[l][i];
                end
            end
        end
        // Final prefix spans [i:0], so carry-in folds in with one AND-OR per bit.
        c[0] = cin;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            c[i+1] = g[LVLS][i] | (p[LVLS][i] & cin);
        end
    end

    assign sum  = p[0] ^ c[DATA_W-1:0];
    assign cout = c[DATA_W];

endmodule

// File: rtl/ksa_rr_arbiter.sv
// Round-robin arbiter sharing one Kogge-Stone adder among NREQ requesters.
module ksa_rr_arbiter
    import ksa_pkg::*;
#(
    parameter int unsigned NREQ = DEFAULT_NREQ,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [DATA_W*NREQ-1:0] req_a,
    input  logic [DATA_W*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]        req_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_sum,
    output logic                   rsp_cout,
    output logic                   busy
);

    state_t            state, state_next;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    sel;
    logic              found;
    logic [DATA_W-1:0] op_a, op_b, add_sum;
    logic              op_cin, add_cout;
    logic [IDW-1:0]    op_id;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(32'(rr_ptr) + k) % NREQ]) begin
                found = 1'b1;
                sel   = IDW'((32'(rr_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[sel] = 1'b1;
                    state_next     = EXEC;
                end
            end
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // req_ready is combinational from req_valid, so mask it while reset is held.
        if (!rst_n) req_ready = '0;
    end

    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_cin   <= 1'b0;
            op_id    <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= '0;
        end else begin
            if (state == IDLE && found) begin
                op_a   <= req_a[int'(sel)*DATA_W +: DATA_W];
                op_b   <= req_b[int'(sel)*DATA_W +: DATA_W];
                op_cin <= req_cin[sel];
                op_id  <= sel;
            end
            if (state == EXEC) begin
                rsp_sum  <= add_sum;
                rsp_cout <= add_cout;
                rsp_id   <= op_id;
            end
            if (state == RESP && rsp_ready) begin
                rr_ptr <= (op_id == IDW'(NREQ - 1)) ? '0 : op_id + 1'b1;
            end
        end
    end

    kogge_stone_adder u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

endmodule
